// File: rtl/booth_mul_arbiter.sv
// Two-port round-robin front end for a shared sequential Booth multiplier.
// One request is accepted at a time, launched with a single start strobe,
// and its product is returned on the granted port. A cycle counter aborts
// an operation whose multiplier never finishes, returning zero and
// raising a sticky timeout flag.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for a request; ready offered to the arbitration winner
// S_LAUNCH  | operands latched, mul_start asserted for this single cycle
// S_WAIT_BUSY | waiting for the multiplier to raise busy
// S_RUN     | multiplier computing; product captured when busy drops
// S_DONE    | response pulse on the granted port
module booth_mul_arbiter #(
   parameter int TIMEOUT = 31
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   input  logic [7:0]  req0_a,
   input  logic [7:0]  req0_b,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [7:0]  req1_a,
   input  logic [7:0]  req1_b,
   output logic        req1_ready,
   output logic        rsp0_valid,
   output logic [15:0] rsp0_result,
   output logic        rsp1_valid,
   output logic [15:0] rsp1_result,
   output logic        mul_start,
   output logic [7:0]  mul_num1,
   output logic [7:0]  mul_num2,
   input  logic [15:0] mul_result,
   input  logic        mul_busy,
   output logic        timeout_err
);

   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT_BUSY,
      S_RUN,
      S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic          last_grant_q, last_grant_d;
   logic          port_q, port_d;
   logic [7:0]    a_q, a_d;
   logic [7:0]    b_q, b_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          mul_start_q, mul_start_d;
   logic          rsp0_valid_q, rsp0_valid_d;
   logic          rsp1_valid_q, rsp1_valid_d;
   logic [15:0]   rsp0_result_q, rsp0_result_d;
   logic [15:0]   rsp1_result_q, rsp1_result_d;
   logic          err_q, err_d;

   logic          grant0, grant1;
   logic          hs0, hs1;
   logic          finish;
   logic [15:0]   finish_val;

   // Round-robin grant: a lone requester always wins; under contention the
   // port not served last wins. Ready is withheld while reset is asserted.
   always_comb begin
      grant0     = req0_valid & (~req1_valid | last_grant_q);
      grant1     = req1_valid & (~req0_valid | ~last_grant_q);
      req0_ready = rst_n & (state_q == S_IDLE) & grant0;
      req1_ready = rst_n & (state_q == S_IDLE) & grant1;
      hs0        = req0_valid & req0_ready;
      hs1        = req1_valid & req1_ready;
   end

   // Next-state and next-output computation for the sequencing FSM.
   always_comb begin
      state_d       = state_q;
      last_grant_d  = last_grant_q;
      port_d        = port_q;
      a_d           = a_q;
      b_d           = b_q;
      cnt_d         = cnt_q;
      mul_start_d   = 1'b0;
      rsp0_valid_d  = 1'b0;
      rsp1_valid_d  = 1'b0;
      rsp0_result_d = rsp0_result_q;
      rsp1_result_d = rsp1_result_q;
      err_d         = err_q;
      finish        = 1'b0;
      finish_val    = 16'h0000;

      unique case (state_q)
         S_IDLE: begin
            if (hs0) begin
               a_d          = req0_a;
               b_d          = req0_b;
               port_d       = 1'b0;
               last_grant_d = 1'b0;
            end else if (hs1) begin
               a_d          = req1_a;
               b_d          = req1_b;
               port_d       = 1'b1;
               last_grant_d = 1'b1;
            end
            if (hs0 || hs1) begin
               state_d     = S_LAUNCH;
               mul_start_d = 1'b1;
               cnt_d       = '0;
            end
         end
         S_LAUNCH: begin
            state_d = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            if (cnt_q == CNT_MAX) begin
               finish = 1'b1;
               err_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
               if (mul_busy) begin
                  state_d = S_RUN;
               end
            end
         end
         S_RUN: begin
            // A finished product wins over a timeout landing on the same cycle.
            if (!mul_busy) begin
               finish     = 1'b1;
               finish_val = mul_result;
            end else if (cnt_q == CNT_MAX) begin
               finish = 1'b1;
               err_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (finish) begin
         state_d = S_DONE;
         if (port_q) begin
            rsp1_valid_d  = 1'b1;
            rsp1_result_d = finish_val;
         end else begin
            rsp0_valid_d  = 1'b1;
            rsp0_result_d = finish_val;
         end
      end
   end

   // State and registered outputs; synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         last_grant_q  <= 1'b1;
         port_q        <= 1'b0;
         a_q           <= 8'h00;
         b_q           <= 8'h00;
         cnt_q         <= '0;
         mul_start_q   <= 1'b0;
         rsp0_valid_q  <= 1'b0;
         rsp1_valid_q  <= 1'b0;
         rsp0_result_q <= 16'h0000;
         rsp1_result_q <= 16'h0000;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         last_grant_q  <= last_grant_d;
         port_q        <= port_d;
         a_q           <= a_d;
         b_q           <= b_d;
         cnt_q         <= cnt_d;
         mul_start_q   <= mul_start_d;
         rsp0_valid_q  <= rsp0_valid_d;
         rsp1_valid_q  <= rsp1_valid_d;
         rsp0_result_q <= rsp0_result_d;
         rsp1_result_q <= rsp1_result_d;
         err_q         <= err_d;
      end
   end

   assign mul_start   = mul_start_q;
   assign mul_num1    = a_q;
   assign mul_num2    = b_q;
   assign rsp0_valid  = rsp0_valid_q;
   assign rsp1_valid  = rsp1_valid_q;
   assign rsp0_result = rsp0_result_q;
   assign rsp1_result = rsp1_result_q;
   assign timeout_err = err_q;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Bench for booth_mul_arbiter: directed and randomized requests on both
// ports, a behavioural multiplier with selectable misbehaviour, and a
// scoreboard predicting grants and products from the arbitration rules.
module tb_booth_mul_arbiter;

   localparam int TO       = 31;
   localparam int M_NORMAL = 0;
   localparam int M_STUCK  = 1;
   localparam int M_IGNORE = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_valid, req1_valid;
   logic [7:0]  req0_a, req0_b, req1_a, req1_b;
   logic        req0_ready, req1_ready;
   logic        rsp0_valid, rsp1_valid;
   logic [15:0] rsp0_result, rsp1_result;
   logic        mul_start;
   logic [7:0]  mul_num1, mul_num2;
   logic [15:0] mul_result;
   logic        mul_busy;
   logic        timeout_err;

   always #5 clk = ~clk;

   booth_mul_arbiter #(.TIMEOUT(TO)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req0_valid  (req0_valid),
      .req0_a      (req0_a),
      .req0_b      (req0_b),
      .req0_ready  (req0_ready),
      .req1_valid  (req1_valid),
      .req1_a      (req1_a),
      .req1_b      (req1_b),
      .req1_ready  (req1_ready),
      .rsp0_valid  (rsp0_valid),
      .rsp0_result (rsp0_result),
      .rsp1_valid  (rsp1_valid),
      .rsp1_result (rsp1_result),
      .mul_start   (mul_start),
      .mul_num1    (mul_num1),
      .mul_num2    (mul_num2),
      .mul_result  (mul_result),
      .mul_busy    (mul_busy),
      .timeout_err (timeout_err)
   );

   // signed 8x8 product truncated to 16 bits
   function automatic logic [15:0] prod(input logic [7:0] a, input logic [7:0] b);
      int x, y;
      x = $signed(a);
      y = $signed(b);
      return 16'(x * y);
   endfunction

   // behavioural multiplier
   int          mode = M_NORMAL;
   int          lat_cfg = 4;
   logic        m_busy = 1'b0;
   logic [15:0] m_res = 16'h0000;
   logic [7:0]  m_a = 8'h00, m_b = 8'h00;
   int          m_cnt = 0;

   assign mul_busy   = m_busy;
   assign mul_result = m_res;

   always @(posedge clk) begin
      if (mode == M_IGNORE) begin
         m_busy <= 1'b0;
      end else if (mul_start) begin
         m_busy <= 1'b1;
         m_cnt  <= lat_cfg;
         m_res  <= 16'hDEAD;
         m_a    <= mul_num1;
         m_b    <= mul_num2;
      end else if (m_busy && mode != M_STUCK) begin
         if (m_cnt == 0) begin
            m_busy <= 1'b0;
            m_res  <= prod(m_a, m_b);
         end else begin
            m_cnt <= m_cnt - 1;
         end
      end
   end

   // bench state
   int          n_pass = 0;
   int          n_total = 0;
   logic [15:0] q0[$];
   logic [15:0] q1[$];
   int          exp_port[$];
   logic [15:0] exp_res[$];
   int          grant_log[$];
   logic        busy_op = 1'b0;
   logic        num_chk = 1'b0;
   logic        exp_start = 1'b0;
   logic        last_g = 1'b1;
   logic [15:0] hold0 = 16'h0000, hold1 = 16'h0000;
   logic [7:0]  cur_a = 8'h00, cur_b = 8'h00;
   logic        drop_en = 1'b0;
   int          cyc = 0, t_start = 0, last_lat = 0;
   int          n_rsp0 = 0, n_rsp1 = 0, n_start = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic drive();
      req0_valid = (q0.size() > 0);
      {req0_a, req0_b} = (q0.size() > 0) ? q0[0] : 16'h0000;
      req1_valid = (q1.size() > 0);
      {req1_a, req1_b} = (q1.size() > 0) ? q1[0] : 16'h0000;
   endtask

   // one clock: observe at negedge, then update stimulus after posedge
   task automatic step();
      logic hs0, hs1, e0, e1, d0, d1;
      int   p;
      logic [15:0] r;
      hs0 = 1'b0;
      hs1 = 1'b0;
      @(negedge clk);
      cyc++;
      if (rst_n) begin
         check("mul_start", mul_start, exp_start);
         if (mul_start) begin
            t_start = cyc;
            n_start++;
         end
         if (num_chk) begin
            check("num1_stable", mul_num1, cur_a);
            check("num2_stable", mul_num2, cur_b);
         end
         if (busy_op) begin
            check("ready_while_busy", {req0_ready, req1_ready}, 2'b00);
         end else begin
            e0 = req0_valid && (!req1_valid || last_g == 1'b1);
            e1 = req1_valid && (!req0_valid || last_g == 1'b0);
            check("grant", {req0_ready, req1_ready}, {e0, e1});
         end
         if (!rsp0_valid) check("rsp0_result_hold", rsp0_result, hold0);
         if (!rsp1_valid) check("rsp1_result_hold", rsp1_result, hold1);
         if (rsp0_valid || rsp1_valid) begin
            check("rsp_single", rsp0_valid & rsp1_valid, 1'b0);
            check("rsp_expected", exp_port.size() > 0, 1'b1);
            if (exp_port.size() > 0) begin
               p = exp_port.pop_front();
               r = exp_res.pop_front();
               check("rsp_port", rsp1_valid, p);
               check("rsp_result", rsp1_valid ? rsp1_result : rsp0_result, r);
            end
            last_lat = cyc - t_start;
            busy_op  = 1'b0;
            num_chk  = 1'b0;
            if (rsp0_valid) begin
               hold0 = rsp0_result;
               n_rsp0++;
            end
            if (rsp1_valid) begin
               hold1 = rsp1_result;
               n_rsp1++;
            end
         end
         hs0 = req0_valid & req0_ready;
         hs1 = req1_valid & req1_ready;
         exp_start = hs0 | hs1;
         if (hs0 || hs1) begin
            p = hs1 ? 1 : 0;
            grant_log.push_back(p);
            last_g = hs1;
            cur_a  = hs1 ? req1_a : req0_a;
            cur_b  = hs1 ? req1_b : req0_b;
            exp_port.push_back(p);
            exp_res.push_back((mode == M_NORMAL) ? prod(cur_a, cur_b) : 16'h0000);
            busy_op = 1'b1;
            num_chk = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      if (hs0) void'(q0.pop_front());
      if (hs1) void'(q1.pop_front());
      d0 = drop_en && !hs0 && req0_valid && q0.size() > 0 && $urandom_range(0, 7) == 0;
      d1 = drop_en && !hs1 && req1_valid && q1.size() > 0 && $urandom_range(0, 7) == 0;
      if (d0) void'(q0.pop_front());
      if (d1) void'(q1.pop_front());
      drive();
      if (d0) req0_valid = 1'b0;
      if (d1) req1_valid = 1'b0;
   endtask

   task automatic run(input int max_cyc);
      int n;
      n = 0;
      while ((q0.size() > 0 || q1.size() > 0 || busy_op) && n < max_cyc) begin
         step();
         n++;
      end
      check("run_bound", n < max_cyc, 1'b1);
   endtask

   // reset for one sampled edge, check reset values while rst_n is low
   task automatic reset_check(input string tag, input logic valids);
      rst_n = 1'b0;
      q0.delete();
      q1.delete();
      exp_port.delete();
      exp_res.delete();
      req0_valid = valids;
      req1_valid = valids;
      busy_op = 1'b0;
      num_chk = 1'b0;
      exp_start = 1'b0;
      last_g = 1'b1;
      hold0 = 16'h0000;
      hold1 = 16'h0000;
      @(posedge clk);
      @(negedge clk);
      check({tag, "_ready"}, {req0_ready, req1_ready}, 2'b00);
      check({tag, "_rsp_valid"}, {rsp0_valid, rsp1_valid}, 2'b00);
      check({tag, "_rsp0_result"}, rsp0_result, 16'h0000);
      check({tag, "_rsp1_result"}, rsp1_result, 16'h0000);
      check({tag, "_mul_start"}, mul_start, 1'b0);
      check({tag, "_mul_nums"}, {mul_num1, mul_num2}, 16'h0000);
      check({tag, "_timeout_err"}, timeout_err, 1'b0);
      rst_n = 1'b1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0, s1, ss, n, pushed;
      rst_n = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      req0_a = 8'h00;
      req0_b = 8'h00;
      req1_a = 8'h00;
      req1_b = 8'h00;

      // reset values, with both requesters asserting valid
      reset_check("rst", 1'b1);

      // single request 38*80
      s0 = n_rsp0; s1 = n_rsp1; ss = n_start;
      lat_cfg = 8;
      q0.push_back({8'd38, 8'd80});
      drive();
      run(200);
      check("single_result", rsp0_result, 16'h0BE0);
      check("single_rsp0_count", n_rsp0 - s0, 1);
      check("single_rsp1_count", n_rsp1 - s1, 0);
      check("single_start_count", n_start - ss, 1);

      // contention right after reset: port 0 first
      reset_check("rst2", 1'b0);
      grant_log.delete();
      lat_cfg = 3;
      q0.push_back({8'd5, 8'd7});
      q1.push_back({8'hFD, 8'd4});
      drive();
      run(200);
      check("contend_grants", grant_log.size(), 2);
      if (grant_log.size() > 0) check("contend_first", grant_log[0], 0);
      check("contend_r0", rsp0_result, 16'h0023);
      check("contend_r1", rsp1_result, 16'hFFF4);

      // fairness: both ports continuously valid for 6 operations
      grant_log.delete();
      for (int i = 0; i < 3; i++) begin
         q0.push_back(16'($urandom));
         q1.push_back(16'($urandom));
      end
      drive();
      run(400);
      check("fair_count", grant_log.size(), 6);
      for (int i = 0; i < grant_log.size() && i < 6; i++) begin
         check("fair_order", grant_log[i], i % 2);
      end

      // randomized traffic with cancellations and varying latency
      drop_en = 1'b1;
      pushed = 0;
      n = 0;
      while ((pushed < 24 || q0.size() > 0 || q1.size() > 0 || busy_op) && n < 4000) begin
         if (pushed < 24 && $urandom_range(0, 3) == 0) begin
            if ($urandom_range(0, 1) == 1) begin
               if (q0.size() < 2) begin
                  q0.push_back(16'($urandom));
                  pushed++;
               end
            end else if (q1.size() < 2) begin
               q1.push_back(16'($urandom));
               pushed++;
            end
            drive();
         end
         lat_cfg = $urandom_range(0, 8);
         step();
         n++;
      end
      drop_en = 1'b0;
      check("random_bound", n < 4000, 1'b1);
      check("random_no_err", timeout_err, 1'b0);

      // timeout with busy stuck high
      mode = M_STUCK;
      lat_cfg = 4;
      q1.push_back({8'd3, 8'd3});
      drive();
      run(200);
      check("stuck_result", rsp1_result, 16'h0000);
      check("stuck_err", timeout_err, 1'b1);
      check("stuck_latency", last_lat >= TO + 1 && last_lat <= TO + 3, 1'b1);

      // normal operation continues, flag stays sticky
      mode = M_NORMAL;
      q0.push_back({8'd2, 8'd2});
      drive();
      run(200);
      check("after_to_result", rsp0_result, 16'h0004);
      check("after_to_err", timeout_err, 1'b1);

      // busy never rises
      mode = M_IGNORE;
      q0.push_back({8'd9, 8'd9});
      drive();
      run(200);
      check("ignore_result", rsp0_result, 16'h0000);
      check("ignore_err", timeout_err, 1'b1);
      check("ignore_latency", last_lat >= TO + 1 && last_lat <= TO + 3, 1'b1);
      mode = M_NORMAL;
      step();
      step();

      // reset while the multiplier is running
      lat_cfg = 8;
      q0.push_back({8'd7, 8'd7});
      drive();
      n = 0;
      while (!(busy_op && mul_busy) && n < 50) begin
         step();
         n++;
      end
      check("mid_reach_run", n < 50, 1'b1);
      step();
      step();
      reset_check("rst_mid", 1'b0);
      repeat (20) step();
      q0.push_back({8'h80, 8'h80});
      drive();
      run(200);
      check("mid_after_result", rsp0_result, 16'h4000);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/booth_mul_arbiter.md
BOOTH_MUL_ARBITER -- requirements
Module: booth_mul_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 31, SHALL set the maximum number of cycles from launch to multiplier completion before abort.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the synchronous, active-low reset.
REQ-004 req0_valid / req1_valid  input  1  SHALL mean the requester has operands pending.
REQ-005 req0_a, req0_b / req1_a, req1_b  input  8 each  SHALL be the two's-complement multiplicand and multiplier.
REQ-006 req0_ready / req1_ready  output  1  SHALL mean the arbiter accepts that port's operands this cycle.
REQ-007 rsp0_valid / rsp1_valid  output  1  SHALL be a one-cycle pulse marking a new product.
REQ-008 rsp0_result / rsp1_result  output  16  SHALL be the product for that port, held until that port's next response.
REQ-009 mul_start  output  1  SHALL be the load/start strobe to the shared Booth multiplier.
REQ-010 mul_num1, mul_num2  output  8 each  SHALL be the operands presented to the multiplier.
REQ-011 mul_result  input  16  SHALL be the multiplier's product.
REQ-012 mul_busy  input  1  SHALL be high while the multiplier computes and low once mul_result is final.
REQ-013 timeout_err  output  1  SHALL be the sticky multiplier-timeout flag.

Function
REQ-014 FSM states SHALL be IDLE, LAUNCH, WAIT_BUSY, RUN and DONE.
REQ-015 IDLE: at most one reqN_ready high; grant only to a port with reqN_valid high.
REQ-016 Both ports valid: grant SHALL go to the port not served last (round-robin pointer last_grant).
REQ-017 One port valid: grant SHALL go to it regardless of last_grant.
REQ-018 A handshake (reqN_valid & reqN_ready) SHALL latch a/b into internal operand registers, record the granted port, update last_grant, and move to LAUNCH.
REQ-019 mul_num1 SHALL equal latched a and mul_num2 latched b; both held stable from LAUNCH through DONE.
REQ-020 LAUNCH: mul_start high for exactly one cycle, then WAIT_BUSY; mul_start low in every other state.
REQ-021 WAIT_BUSY: remain until mul_busy = 1, then go to RUN.
REQ-022 RUN: on the first cycle with mul_busy = 0, capture mul_result into the granted port's result register and go to DONE.
REQ-023 DONE: granted port's rspN_valid high for one cycle, other rsp_valid low, then IDLE.
REQ-024 The arbiter SHALL NOT alter the product: result is a 16-bit pass-through, no sign handling.
REQ-025 A cycle counter SHALL clear on entry to LAUNCH and increment in WAIT_BUSY and RUN.
REQ-026 Counter reaching TIMEOUT before capture SHALL force DONE with result 16'h0000, set timeout_err = 1, and still pulse rspN_valid.
REQ-027 timeout_err SHALL stay high until reset; later operations SHALL proceed normally.
REQ-028 A port's operands arriving while the arbiter is busy SHALL wait (ready low) with no loss; reqN_valid drop before handshake SHALL cancel that request.

Reset
REQ-029 rst_n low at a clock edge SHALL force IDLE regardless of state, including mid-operation; the in-flight product is discarded and no response issued.
REQ-030 Reset values: req0_ready = req1_ready = 0, rsp0_valid = rsp1_valid = 0, rsp0_result = rsp1_result = 16'h0000, mul_start = 0, mul_num1 = mul_num2 = 8'h00, timeout_err = 0, counter = 0.
REQ-031 Reset SHALL set last_grant = 1 so port 0 wins the first contended arbitration.

Verification
REQ-032 Single request: req0 a = 38, b = 80, model busy 8 cycles -> mul_start one pulse, rsp0_valid one pulse, rsp0_result = 3040 (16'h0BE0), rsp1_valid never high.
REQ-033 Contention after reset: req0 5*7, req1 -3*4 same cycle -> port 0 served first, rsp0_result = 35 (16'h0023), then rsp1_result = -12 (16'hFFF4).
REQ-034 Fairness: both ports valid continuously for 6 operations -> grants alternate 0,1,0,1,0,1; each operand pair held stable during its operation.
REQ-035 Timeout: model raises mul_busy and never drops it, req1 3*3 -> at counter = 31, rsp1_valid pulse, rsp1_result = 16'h0000, timeout_err = 1 and stays 1; next req0 2*2 returns 16'h0004.
REQ-036 Reset mid-operation: rst_n low for one cycle during RUN -> all outputs at REQ-030 values next cycle, no rsp pulse; new req0 -128*-128 returns 16'h4000.
REQ-037 Busy never rising: model ignores mul_start -> timeout path per REQ-026 taken from WAIT_BUSY.
